// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants, FSM state type and width helper for the
//                FFT peak detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N  = 512;
    localparam int FFT_DW = 16;
    localparam int FFT_BW = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FLUSH  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Width of an unsigned re^2 + im^2 for DW-bit signed operands.
    function automatic int pow_width(input int dw);
        return 2 * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_power_calc.sv
`default_nettype none
// ============================================================================
//  Module      : fft_power_calc
//  Description : Two-stage power pipeline. Stage 1 squares the real and
//                imaginary parts; stage 2 sums them. The beat's sop flag and
//                bin index travel alongside. Each stage loads only when the
//                stage feeding it holds a valid beat.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                in_valid/in_sop  - beat valid / first-beat tag
//                in_bin           - bin index of the beat
//                in_real/in_imag  - signed sample components
//                pow_valid/pow_sop/pow_bin/pow - stage-2 result
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_power_calc
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int BW = FFT_BW
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_sop,
    input  logic [BW-1:0]             in_bin,
    input  logic [DW-1:0]             in_real,
    input  logic [DW-1:0]             in_imag,
    output logic                      pow_valid,
    output logic                      pow_sop,
    output logic [BW-1:0]             pow_bin,
    output logic [pow_width(DW)-1:0]  pow
);

    localparam int PW = pow_width(DW);

    // Sign-extend before multiplying so the PW-bit product is exact.
    // The largest square, (-2^(DW-1))^2, still fits below the sign bit.
    logic signed [PW-1:0] w_re_ext;
    logic signed [PW-1:0] w_im_ext;
    logic        [PW-1:0] w_re_sq;
    logic        [PW-1:0] w_im_sq;

    assign w_re_ext = PW'($signed(in_real));
    assign w_im_ext = PW'($signed(in_imag));
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    logic          r1_valid;
    logic          r1_sop;
    logic [BW-1:0] r1_bin;
    logic [PW-1:0] r1_re_sq;
    logic [PW-1:0] r1_im_sq;

    logic          r2_valid;
    logic          r2_sop;
    logic [BW-1:0] r2_bin;
    logic [PW-1:0] r2_pow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sop   <= 1'b0;
            r1_bin   <= '0;
            r1_re_sq <= '0;
            r1_im_sq <= '0;
        end else begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_sop   <= in_sop;
                r1_bin   <= in_bin;
                r1_re_sq <= w_re_sq;
                r1_im_sq <= w_im_sq;
            end
        end
    end

    // Each square is at most 2^(PW-2), so the sum is at most 2^(PW-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_sop   <= 1'b0;
            r2_bin   <= '0;
            r2_pow   <= '0;
        end else begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sop <= r1_sop;
                r2_bin <= r1_bin;
                r2_pow <= r1_re_sq + r1_im_sq;
            end
        end
    end

    assign pow_valid = r2_valid;
    assign pow_sop   = r2_sop;
    assign pow_bin   = r2_bin;
    assign pow       = r2_pow;

endmodule
`default_nettype wire

// File: rtl/fft_peak_detect.sv
`default_nettype none
// ============================================================================
//  Module      : fft_peak_detect
//  Description : Consumes one FFT output frame, computes per-bin power and
//                reports the index and power of the strongest bin inside the
//                search window [MIN_BIN, MAX_BIN]. Malformed frames raise a
//                one-cycle error pulse and leave the reported peak unchanged.
//  Ports       : clk, rst_n                - clock, async active-low reset
//                source_valid/sop/eop      - FFT source stream framing
//                source_real/source_imag   - signed bin components
//                peak_bin/peak_pow         - last good frame's peak
//                frame_done/frame_err      - one-cycle result pulses
//                busy                      - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int DW      = FFT_DW,
    parameter int N       = FFT_N,
    parameter int BW      = FFT_BW,
    parameter int MIN_BIN = 1,
    parameter int MAX_BIN = 255
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     source_valid,
    input  logic                     source_sop,
    input  logic                     source_eop,
    input  logic [DW-1:0]            source_real,
    input  logic [DW-1:0]            source_imag,
    output logic [BW-1:0]            peak_bin,
    output logic [pow_width(DW)-1:0] peak_pow,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int            PW       = pow_width(DW);
    localparam logic [BW:0]   LAST_IDX = (BW+1)'(N - 1);
    localparam logic [BW:0]   OVER_IDX = (BW+1)'(N);
    localparam logic [BW-1:0] MIN_IDX  = BW'(MIN_BIN);

    // ------------------------------------------------------------------
    // Frame-control FSM
    // ------------------------------------------------------------------
    state_t        r_state,    w_state_nxt;
    logic [BW:0]   r_idx,      w_idx_nxt;     // index the next beat will take
    logic [1:0]    r_flush,    w_flush_nxt;
    logic          r_busy,     w_busy_nxt;
    logic          r_done,     w_done_nxt;
    logic          r_err,      w_err_nxt;
    logic [BW-1:0] r_peak_bin, w_peak_bin_nxt;
    logic [PW-1:0] r_peak_pow, w_peak_pow_nxt;

    // Beat forwarded into the power pipeline
    logic          w_fwd;
    logic          w_fwd_sop;
    logic [BW-1:0] w_fwd_bin;

    // Running maximum (stage 3)
    logic          r_have;
    logic [BW-1:0] r_max_bin;
    logic [PW-1:0] r_max_pow;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_flush_nxt    = r_flush;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_peak_bin_nxt = r_peak_bin;
        w_peak_pow_nxt = r_peak_pow;
        w_fwd          = 1'b0;
        w_fwd_sop      = 1'b0;
        w_fwd_bin      = r_idx[BW-1:0];

        case (r_state)
            IDLE: begin
                if (source_valid && source_sop) begin
                    w_fwd       = 1'b1;
                    w_fwd_sop   = 1'b1;
                    w_fwd_bin   = '0;
                    w_idx_nxt   = (BW+1)'(1);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end

            ACCUM: begin
                if (source_valid) begin
                    if (source_sop) begin
                        // Restart: the old frame is abandoned, the new one
                        // begins with this beat as bin 0.
                        w_err_nxt = 1'b1;
                        w_fwd     = 1'b1;
                        w_fwd_sop = 1'b1;
                        w_fwd_bin = '0;
                        w_idx_nxt = (BW+1)'(1);
                    end else if ((r_idx == OVER_IDX) ||
                                 (source_eop && (r_idx != LAST_IDX))) begin
                        // Either eop arrived early, or a beat arrived past
                        // the last bin without an eop having been seen.
                        w_err_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_fwd     = 1'b1;
                        w_idx_nxt = r_idx + (BW+1)'(1);
                        if (source_eop) begin
                            w_flush_nxt = '0;
                            w_state_nxt = FLUSH;
                        end
                    end
                end
            end

            FLUSH: begin
                // Three cycles lets the eop beat clear stage 3 with margin,
                // fixing the eop-to-done latency independent of stalls.
                if (r_flush == 2'd2) begin
                    w_state_nxt = REPORT;
                end else begin
                    w_flush_nxt = r_flush + 2'd1;
                end
            end

            REPORT: begin
                w_peak_bin_nxt = r_max_bin;
                w_peak_pow_nxt = r_max_pow;
                w_done_nxt     = 1'b1;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_flush    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_peak_bin <= '0;
            r_peak_pow <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_flush    <= w_flush_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_peak_bin <= w_peak_bin_nxt;
            r_peak_pow <= w_peak_pow_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Stages 1-2: power computation
    // ------------------------------------------------------------------
    logic          w_pow_valid;
    logic          w_pow_sop;
    logic [BW-1:0] w_pow_bin;
    logic [PW-1:0] w_pow;

    fft_power_calc #(
        .DW (DW),
        .BW (BW)
    ) u_power_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_fwd),
        .in_sop    (w_fwd_sop),
        .in_bin    (w_fwd_bin),
        .in_real   (source_real),
        .in_imag   (source_imag),
        .pow_valid (w_pow_valid),
        .pow_sop   (w_pow_sop),
        .pow_bin   (w_pow_bin),
        .pow       (w_pow)
    );

    // ------------------------------------------------------------------
    // Stage 3: running maximum
    // The clear is carried by the sop tag rather than done by the FSM, so
    // beats of an abandoned frame still in flight cannot pollute the new
    // frame's maximum.
    // ------------------------------------------------------------------
    logic w_in_win;
    assign w_in_win = (int'(w_pow_bin) >= MIN_BIN) && (int'(w_pow_bin) <= MAX_BIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_have    <= 1'b0;
            r_max_bin <= '0;
            r_max_pow <= '0;
        end else if (w_pow_valid) begin
            if (w_pow_sop) begin
                r_have    <= w_in_win;
                r_max_bin <= w_in_win ? w_pow_bin : MIN_IDX;
                r_max_pow <= w_in_win ? w_pow : '0;
            end else if (w_in_win && (!r_have || (w_pow > r_max_pow))) begin
                // Strict compare keeps the lowest index on ties.
                r_have    <= 1'b1;
                r_max_bin <= w_pow_bin;
                r_max_pow <= w_pow;
            end
        end
    end

    assign peak_bin   = r_peak_bin;
    assign peak_pow   = r_peak_pow;
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Downstream consumer of the FFT core source stream, one clock domain.
- Takes one N-point output frame (source_valid/sop/eop plus real/imag), computes per-bin power re^2 + im^2, and tracks the maximum over a bin window.
- Reports peak bin index and power once per frame.
- Feeds the tone-selection/control logic that drives filt_mux-style decisions.

Parameters:
- DW, 16, width of signed source_real/source_imag.
- N, 512, FFT frame length in beats; matches the FFT sink frame length.
- BW, 9, bin index width; equals clog2(N).
- MIN_BIN, 1, first bin searched; default excludes DC.
- MAX_BIN, 255, last bin searched, inclusive; default is the positive-frequency half.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- source_valid  in  1  FFT output beat valid.
- source_sop  in  1  first beat of frame; qualified by source_valid.
- source_eop  in  1  last beat of frame; qualified by source_valid.
- source_real  in  DW  signed real part.
- source_imag  in  DW  signed imaginary part.
- peak_bin  out  BW  index of maximum-power bin of the last good frame.
- peak_pow  out  2*DW  unsigned power of that bin.
- frame_done  out  1  one-cycle pulse when peak_bin/peak_pow update.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- busy  out  1  high from accepted sop until done/err pulse.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; bin counter 0; running max 0.
- Beat definition: one beat = source_valid high on a clk edge. Cycles with valid low are stalls: no counting, pipeline bubbles.
- FSM states and transitions:
  - IDLE: a beat with sop starts a frame, bin=0, clears the running max, goes to ACCUM. Beats without sop are ignored.
  - ACCUM: each beat increments bin.
    - eop on beat with bin==N-1: goes to FLUSH.
    - eop with bin!=N-1: frame_err pulse, goes to IDLE.
    - sop mid-frame: frame_err pulse, restarts the frame at bin=0 and stays in ACCUM.
    - bin reaching N-1 without eop: the next beat is treated as an error, as for a premature eop.
  - FLUSH: waits for the pipeline to drain, then REPORT.
  - REPORT: one cycle. Registers peak outputs, pulses frame_done, goes to IDLE.
- Pipeline, 3 stages, each advancing only with its valid bit:
  - S1 registers re*re and im*im as 2*DW-bit unsigned values (max 2^30 each).
  - S2 sums them into 2*DW bits unsigned; max 2^31, no overflow.
  - S3 compares and updates the running max.
- Comparison rule: a bin updates the max only if MIN_BIN <= bin <= MAX_BIN and pow > max (strict). Ties keep the lowest index.
- If every in-window bin has power 0, peak_bin=MIN_BIN and peak_pow=0. The first in-window bin always loads the max.
- Latency: frame_done is high exactly 4 clk after the eop beat, given no reset.
- busy drops in the same cycle frame_done or frame_err pulses.
- peak_bin/peak_pow hold until the next good frame; errored frames leave them unchanged.
- A sop arriving while in FLUSH/REPORT is ignored; the upstream guarantees a gap of at least 4 cycles between frames.
- Reset mid-frame: immediate return to IDLE, outputs cleared, no pulses.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N=512, FFT_DW=16, FFT_BW=9;
  - the state enum (IDLE, ACCUM, FLUSH, REPORT);
  - a function for the power width (2*DW).
- One natural sub-module: fft_power_calc, containing S1–S2 (square, sum, and valid/bin-index delay line).

Test Plan:
- Single tone: frame where bin 37 has re=1000, im=0 and all other bins re=im=1. Result: frame_done 4 cycles after eop, peak_bin=37, peak_pow=1_000_000.
- Window limits: DC bin 0 re=32767, bin 300 re=20000, bin 12 re=500, rest 0. Result: peak_bin=12, peak_pow=250_000.
- Extreme value plus tie: bins 50 and 60 both re=-32768, im=-32768. Result: peak_bin=50, peak_pow=2^31 with no overflow.
- Stalls: valid toggling 1-0-1 every other cycle through a tone-at-bin-100 frame. Results must match the no-stall run; latency of 4 cycles is measured from the eop beat.
- Malformed frames:
  - eop at beat 300 gives a frame_err pulse and no frame_done; previous peak outputs are held.
  - sop at beat 200 gives frame_err, then a full 512-beat frame from that sop reports correctly.
- Reset mid-frame: rst_n low at beat 256, then a fresh good frame. Results: no pulses during reset, outputs 0, and the next frame reports correctly.
